// File: rtl/accum_bank_if.sv
// rtl/accum_bank_if.sv - command and dump-readout signal bundle for accum_bank
interface accum_bank_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
);
    localparam int CW = $clog2(CHANNELS);

    logic             clr;
    logic             ld;
    logic             sub;
    logic             sat;
    logic [CW-1:0]    ch;
    logic [WIDTH-1:0] d;
    logic             dump;
    logic             ready;
    logic             q_valid;
    logic [CW-1:0]    q_ch;
    logic [WIDTH-1:0] q;
    logic             q_ovf;

    modport master (
        output clr, ld, sub, sat, ch, d, dump,
        input  ready, q_valid, q_ch, q, q_ovf
    );

    modport slave (
        input  clr, ld, sub, sat, ch, d, dump,
        output ready, q_valid, q_ch, q, q_ovf
    );
endinterface

// File: rtl/accum_bank.sv
// rtl/accum_bank.sv - bank of add/sub accumulators with sticky overflow and sequential read-and-clear dump
module accum_bank #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    accum_bank_if.slave  bus
);
    localparam int            CW   = $clog2(CHANNELS);
    localparam logic [CW-1:0] LAST = CW'(CHANNELS - 1);
    localparam logic [CW:0]   NCH  = (CW + 1)'(CHANNELS);

    typedef enum logic {S_IDLE, S_DUMPING} state_t;

    state_t           state, state_n;
    logic [CW-1:0]    idx;
    logic [WIDTH-1:0] acc [CHANNELS];
    logic             ovf [CHANNELS];

    logic             ch_ok;
    logic             ld_go;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] diff;
    logic             op_ovf;
    logic [WIDTH-1:0] op_res;

    // Operand fetch and add/subtract with overflow detect and optional clamping
    always_comb begin
        ch_ok  = ({1'b0, bus.ch} < NCH);
        opnd   = ch_ok ? acc[bus.ch] : '0;
        sum    = {1'b0, opnd} + {1'b0, bus.d};
        diff   = opnd - bus.d;
        op_ovf = 1'b0;
        op_res = '0;
        if (bus.sub) begin
            op_ovf = (bus.d > opnd);
            op_res = (op_ovf && bus.sat) ? '0 : diff;
        end else begin
            op_ovf = sum[WIDTH];
            op_res = (op_ovf && bus.sat) ? '1 : sum[WIDTH-1:0];
        end
        ld_go  = bus.ld && ch_ok && !bus.clr && (state == S_IDLE);
    end

    // Next-state selection and readout outputs, which are zero outside a dump
    always_comb begin
        state_n     = state;
        bus.ready   = (state == S_IDLE);
        bus.q_valid = (state == S_DUMPING);
        bus.q_ch    = '0;
        bus.q       = '0;
        bus.q_ovf   = 1'b0;
        if (state == S_DUMPING) begin
            bus.q_ch  = idx;
            bus.q     = acc[idx];
            bus.q_ovf = ovf[idx];
        end
        if (bus.clr) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    if (bus.dump) state_n = S_DUMPING;
                S_DUMPING: if (idx == LAST) state_n = S_IDLE;
                default:   state_n = S_IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    // Accumulators, overflow flags and dump index; clear beats load, load lands before a dump starts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                acc[i] <= '0;
                ovf[i] <= 1'b0;
            end
        end else if (bus.clr) begin
            idx <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                acc[i] <= '0;
                ovf[i] <= 1'b0;
            end
        end else if (state == S_IDLE) begin
            if (ld_go) begin
                acc[bus.ch] <= op_res;
                if (op_ovf) ovf[bus.ch] <= 1'b1;
            end
            if (bus.dump) idx <= '0;
        end else begin
            acc[idx] <= '0;
            ovf[idx] <= 1'b0;
            idx      <= (idx == LAST) ? '0 : idx + CW'(1);
        end
    end
endmodule

// File: tb/tb_accum_bank.sv
// tb/tb_accum_bank.sv - self-checking bench for accum_bank
module tb_accum_bank;
    localparam int W = 8;
    localparam int N = 4;

    logic clk;
    logic rst_n;

    accum_bank_if #(.WIDTH(W), .CHANNELS(N)) bus();

    accum_bank #(.WIDTH(W), .CHANNELS(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;

    // behavioural reference: plain integer accumulators plus dump progress
    int m_acc [N];
    bit m_ovf [N];
    bit m_dumping;
    int m_idx;

    typedef struct {
        int ch;
        int pre;
        bit sub;
        bit sat;
        int d;
        int exp_q;
        bit exp_ovf;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input int act, input int exp);
        vec_cnt++;
        if (act != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_acc[i] = 0;
            m_ovf[i] = 0;
        end
        m_dumping = 0;
        m_idx     = 0;
    endtask

    task automatic model_op(input int ch, input bit sub, input bit sat, input int d);
        int r;
        r = sub ? m_acc[ch] - d : m_acc[ch] + d;
        if (r < 0 || r > 255) begin
            m_ovf[ch] = 1;
            if (sat) r = (r < 0) ? 0 : 255;
            else     r = ((r % 256) + 256) % 256;
        end
        m_acc[ch] = r;
    endtask

    task automatic check_outputs();
        check("ready",   int'(bus.ready),   m_dumping ? 0 : 1);
        check("q_valid", int'(bus.q_valid), m_dumping ? 1 : 0);
        check("q_ch",    int'(bus.q_ch),    m_dumping ? m_idx : 0);
        check("q",       int'(bus.q),       m_dumping ? m_acc[m_idx] : 0);
        check("q_ovf",   int'(bus.q_ovf),   m_dumping ? int'(m_ovf[m_idx]) : 0);
    endtask

    // drive one cycle of inputs, compare current outputs, clock, advance the model
    task automatic step(input bit ld, input bit sub, input bit sat, input int ch,
                        input int d, input bit dump, input bit clr);
        bus.ld   = ld;
        bus.sub  = sub;
        bus.sat  = sat;
        bus.ch   = 2'(ch);
        bus.d    = 8'(d);
        bus.dump = dump;
        bus.clr  = clr;
        check_outputs();
        @(posedge clk);
        if (clr) begin
            model_reset();
        end else if (!m_dumping) begin
            if (ld && ch < N) model_op(ch, sub, sat, d);
            if (dump) begin
                m_dumping = 1;
                m_idx     = 0;
            end
        end else begin
            m_acc[m_idx] = 0;
            m_ovf[m_idx] = 0;
            if (m_idx == N - 1) m_dumping = 0;
            m_idx = (m_idx + 1) % N;
        end
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic load(input int ch, input bit sub, input bit sat, input int d);
        step(1, sub, sat, ch, d, 0, 0);
    endtask

    initial begin
        tbl[0] = '{ch: 0, pre: 10,  sub: 0, sat: 0, d: 5,   exp_q: 15,  exp_ovf: 0};
        tbl[1] = '{ch: 1, pre: 200, sub: 0, sat: 1, d: 100, exp_q: 255, exp_ovf: 1};
        tbl[2] = '{ch: 1, pre: 200, sub: 0, sat: 0, d: 100, exp_q: 44,  exp_ovf: 1};
        tbl[3] = '{ch: 2, pre: 10,  sub: 1, sat: 1, d: 20,  exp_q: 0,   exp_ovf: 1};
        tbl[4] = '{ch: 2, pre: 10,  sub: 1, sat: 0, d: 20,  exp_q: 246, exp_ovf: 1};
        tbl[5] = '{ch: 3, pre: 255, sub: 0, sat: 1, d: 0,   exp_q: 255, exp_ovf: 0};
        tbl[6] = '{ch: 3, pre: 255, sub: 0, sat: 0, d: 1,   exp_q: 0,   exp_ovf: 1};
        tbl[7] = '{ch: 3, pre: 5,   sub: 1, sat: 1, d: 5,   exp_q: 0,   exp_ovf: 0};
        tbl[8] = '{ch: 0, pre: 0,   sub: 1, sat: 0, d: 1,   exp_q: 255, exp_ovf: 1};
        tbl[9] = '{ch: 2, pre: 100, sub: 1, sat: 0, d: 1,   exp_q: 99,  exp_ovf: 0};

        bus.ld = 0; bus.sub = 0; bus.sat = 0; bus.ch = '0; bus.d = '0;
        bus.dump = 0; bus.clr = 0;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // three adds of 5 on channel 0, then dump
        load(0, 0, 0, 5);
        load(0, 0, 0, 5);
        load(0, 0, 0, 5);
        step(0, 0, 0, 0, 0, 1, 0);
        check("seq_first_word", int'(bus.q), 15);
        for (int k = 0; k < N; k++) idle();
        idle();

        // table of single-operation arithmetic cases
        for (int v = 0; v < 10; v++) begin
            step(0, 0, 0, 0, 0, 0, 1);
            load(tbl[v].ch, 0, 0, tbl[v].pre);
            load(tbl[v].ch, tbl[v].sub, tbl[v].sat, tbl[v].d);
            step(0, 0, 0, 0, 0, 1, 0);
            for (int k = 0; k < N; k++) begin
                if (k == tbl[v].ch) begin
                    check($sformatf("tbl%0d_q", v), int'(bus.q), tbl[v].exp_q);
                    check($sformatf("tbl%0d_ovf", v), int'(bus.q_ovf), int'(tbl[v].exp_ovf));
                end
                idle();
            end
        end

        // full dump with loads attempted during it, then an empty second dump
        step(0, 0, 0, 0, 0, 0, 1);
        for (int c = 0; c < N; c++) load(c, 0, 0, c + 1);
        step(0, 0, 0, 0, 0, 1, 0);
        for (int k = 0; k < N; k++) begin
            check("dump_ready_low", int'(bus.ready), 0);
            check("dump_word", int'(bus.q), k + 1);
            step(1, 0, 0, k, 50, 1, 0);
        end
        check("dump_done", int'(bus.q_valid), 0);
        step(0, 0, 0, 0, 0, 1, 0);
        for (int k = 0; k < N; k++) begin
            check("second_dump_zero", int'(bus.q), 0);
            idle();
        end

        // load on the same edge as dump start, then clear in the second dump cycle
        load(3, 0, 0, 1);
        step(1, 0, 0, 3, 7, 1, 0);
        idle();
        step(0, 0, 0, 0, 0, 0, 1);
        check("clr_abort_valid", int'(bus.q_valid), 0);
        load(3, 0, 0, 1);
        step(1, 0, 0, 3, 7, 1, 0);
        for (int k = 0; k < N; k++) begin
            if (k == 3) check("ld_with_dump", int'(bus.q), 8);
            idle();
        end
        step(0, 0, 0, 0, 0, 1, 0);
        idle();
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1, 0);
        for (int k = 0; k < N; k++) idle();

        // asynchronous reset in the middle of a dump, between clock edges
        load(1, 0, 0, 9);
        load(2, 0, 1, 250);
        load(2, 0, 1, 250);
        step(0, 0, 0, 0, 0, 1, 0);
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_ready",   int'(bus.ready),   1);
        check("arst_q_valid", int'(bus.q_valid), 0);
        check("arst_q",       int'(bus.q),       0);
        check("arst_q_ch",    int'(bus.q_ch),    0);
        check("arst_q_ovf",   int'(bus.q_ovf),   0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(0, 0, 0, 0, 0, 1, 0);
        for (int k = 0; k < N; k++) idle();
        idle();

        // randomized traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            bit r_ld, r_sub, r_sat, r_dump, r_clr;
            int r_ch, r_d;
            r_ld   = ($urandom_range(0, 1) == 1);
            r_sub  = ($urandom_range(0, 2) == 0);
            r_sat  = ($urandom_range(0, 1) == 1);
            r_ch   = $urandom_range(0, N - 1);
            r_d    = ($urandom_range(0, 3) == 0) ? $urandom_range(200, 255) : $urandom_range(0, 60);
            r_dump = ($urandom_range(0, 11) == 0);
            r_clr  = ($urandom_range(0, 49) == 0);
            step(r_ld, r_sub, r_sat, r_ch, r_d, r_dump, r_clr);
        end
        step(0, 0, 0, 0, 0, 1, 0);
        for (int k = 0; k < N + 1; k++) idle();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/accum_bank.md
ACCUM_BANK -- requirements
Module: accum_bank

Interface
REQ-001 Parameter WIDTH, default 8, bit width of D, of each accumulator and of Q.
REQ-002 Parameter CHANNELS, default 4, number of independent accumulators (2 or more); CW = $clog2(CHANNELS).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 RST_N  input  1  reset; asynchronous, active-low.
REQ-005 CLR  input  1  synchronous clear of all channels; aborts a dump.
REQ-006 LD  input  1  load strobe; accepted only when READY=1.
REQ-007 SUB  input  1  0 adds D to the selected channel; 1 subtracts D from it.
REQ-008 SAT  input  1  1 selects saturating arithmetic; 0 selects wrap (mod 2^WIDTH).
REQ-009 CH  input  CW  target channel for LD.
REQ-010 D  input  WIDTH  unsigned operand.
REQ-011 DUMP  input  1  start a sequential read-and-clear of all channels.
REQ-012 READY  output  1  high when LD is accepted (state IDLE).
REQ-013 Q_VALID  output  1  high while a dump word is presented.
REQ-014 Q_CH  output  CW  channel index of the presented word.
REQ-015 Q  output  WIDTH  accumulator value of channel Q_CH.
REQ-016 Q_OVF  output  1  sticky overflow flag of channel Q_CH.

Function
REQ-017 FSM states: IDLE, DUMPING; READY = (state==IDLE); Q_VALID = (state==DUMPING).
REQ-018 Accepted LD (READY=1, CH<CHANNELS, CLR=0) updates acc[CH] at the next edge; only that channel changes.
REQ-019 LD with CH >= CHANNELS is ignored; no state changes.
REQ-020 Arithmetic uses a WIDTH+1-bit result; add overflow = result > 2^WIDTH-1; sub overflow = D > acc[CH].
REQ-021 SAT=1: add overflow clamps to 2^WIDTH-1, sub overflow clamps to 0.
REQ-022 SAT=0: result taken mod 2^WIDTH.
REQ-023 Any overflow, in either mode, sets ovf[CH]; ovf clears only by dump, CLR or reset.
REQ-024 IDLE with DUMP=1 and CLR=0: next state DUMPING, index 0; an LD accepted on the same edge is applied first, so the dump includes it.
REQ-025 DUMPING: Q_CH=index, Q=acc[index], Q_OVF=ovf[index]; each edge clears acc[index] and ovf[index] and increments index.
REQ-026 Edge with index==CHANNELS-1 in DUMPING returns to IDLE; Q_VALID is high for exactly CHANNELS consecutive cycles.
REQ-027 In DUMPING, LD and DUMP are ignored.
REQ-028 Q, Q_CH and Q_OVF are driven 0 when Q_VALID=0.
REQ-029 CLR=1 has priority over LD and DUMP: next edge zeroes all acc and ovf, index=0, state IDLE; a dump in progress is aborted and its remaining words are not presented.

Reset
REQ-030 RST_N=0 immediately forces all acc=0, all ovf=0, index=0, state IDLE; outputs READY=1, Q_VALID=0, Q=0, Q_CH=0, Q_OVF=0, independent of clk.
REQ-031 Reset asserted mid-dump aborts the dump; after release, the block is in IDLE with all channels zero.

Verification (WIDTH=8, CHANNELS=4)
REQ-032 Reset; LD ch0 with D=5 three times, SAT=0; DUMP -> first word: Q_CH=0, Q=15, Q_OVF=0; channels 1-3 read 0.
REQ-033 SAT=1: add 200 then 100 on ch1 -> dump Q=255, Q_OVF=1; repeat with SAT=0 -> Q=44, Q_OVF=1.
REQ-034 Load ch2 with 10, then SUB=1 with D=20: SAT=1 -> Q=0, Q_OVF=1; SAT=0 -> Q=246, Q_OVF=1.
REQ-035 Load ch0..ch3 with 1,2,3,4; DUMP -> Q_VALID high 4 cycles, Q_CH 0..3, Q 1..4, READY low throughout; LD presented during the dump is ignored; second DUMP reads all 0.
REQ-036 Simultaneous LD ch3 D=7 and DUMP with acc[3]=1 -> ch3 word is 8. CLR during the 2nd dump cycle -> Q_VALID drops next cycle, all channels read 0.
REQ-037 RST_N low mid-dump and between clock edges -> outputs reset without a clock edge; after release, READY=1 and a DUMP reads all 0.
